mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Accumulation stage directly downstream of `multiplier` in the convolution datapath. It consumes the stream of scaled, signed products from the multiplier and sums one group of products, e.g. one kernel window, into a wide two's-complement accumulator. The end of a group is marked by `in_last`. The block then rescales the sum, saturates it to the output width and presents it on a valid/ready output register.

## Interface
- `IN_WIDTH`, 15: width of the signed product input; equals multiplier `OUT_WIDTH`.
- `ACC_WIDTH`, 32: width of the signed internal accumulator; must be > `IN_WIDTH`.
- `OUT_WIDTH`, 16: width of the signed result.
- `OUT_SHIFT`, 0: arithmetic right shift applied to the final sum before saturation; range 0..`ACC_WIDTH`-1.
- `CNT_WIDTH`, 8: width of the term counter.
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_data`/`in_last` carry a product.
- `in_ready`, out, 1: block accepts a product this cycle.
- `in_data`, in, `IN_WIDTH`: signed product.
- `in_last`, in, 1: this product closes the current group.
- `out_valid`, out, 1: result register holds an unconsumed result.
- `out_ready`, in, 1: consumer accepts the result this cycle.
- `out_data`, out, `OUT_WIDTH`: signed, shifted, saturated group sum.
- `out_sat`, out, 1: `out_data` was clipped.
- `out_terms`, out, `CNT_WIDTH`: number of products in the group, modulo 2^`CNT_WIDTH`.

## Operation
- Input handshake: a product is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational from `out_valid`/`out_ready`; there is no skid buffer.
- Accumulator state machine:
  - EMPTY: the next accepted product starts a new group. `acc <= sext(in_data)` and `cnt <= 1`.
  - RUN: a group is in progress. `acc <= acc + sext(in_data)` and `cnt <= cnt + 1`.
- Transitions:
  - EMPTY -> RUN on an accepted product with `in_last=0`.
  - RUN stays in RUN on an accepted product with `in_last=0`.
  - Any state -> EMPTY on an accepted product with `in_last=1`.
  - No accepted product: state and `acc` hold.
- On an accepted `in_last` product, the final sum `s` is the value `acc` would take that cycle.
  - `t = s >>> OUT_SHIFT`, using arithmetic shift (rounds toward −inf).
  - `t` above 2^(`OUT_WIDTH`−1)−1: `out_data` is the maximum and `out_sat=1`.
  - `t` below −2^(`OUT_WIDTH`−1): `out_data` is the minimum and `out_sat=1`.
  - Otherwise `out_data = t` and `out_sat=0`.
  - `out_terms` is the new `cnt`. `out_valid <= 1`.
- A single-product group (accepted in EMPTY with `in_last=1`) gives `s = sext(in_data)` and `out_terms = 1`.
- Accumulator overflow: `acc` wraps modulo 2^`ACC_WIDTH` and is not detected. `out_sat` reflects only the output clipping.
- Output handshake:
  - A result is consumed when `out_valid && out_ready`.
  - If it is consumed without a new result arriving in the same cycle, `out_valid <= 0`.
  - If a consume and a new `in_last` acceptance happen in the same cycle, the new result loads and `out_valid` stays 1.
- While `out_valid && !out_ready`: `out_data`, `out_sat` and `out_terms` are held stable, and `in_ready = 0`.
- Counter wrap: `cnt` wraps modulo 2^`CNT_WIDTH`; summation is unaffected.

## Timing
- Reset, synchronous, takes priority over all other activity: state=EMPTY, `acc`=0, `cnt`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, `out_terms`=0.
- `in_ready` is 1 in the cycle after reset.
- Reset asserted mid-group discards the partial sum and any held result.
- Latency is one cycle: `out_valid` rises on the clock edge that accepts the `in_last` product.
- Throughput is one product per cycle while `out_ready=1`. Back-to-back groups need no idle cycles.
- `in_valid` may drop between products of a group; the partial sum holds.
- There is no combinational path from `in_*` to `out_*`.

## Test plan
All scenarios use the defaults unless stated.
- Group of 100, −30, 5 (`last` on 5), `out_ready=1` -> one cycle later `out_data=75`, `out_sat=0`, `out_terms=3`, `out_valid` high for exactly one cycle.
- Single product −16384 with `last` -> `out_data=−16384`, `out_terms=1`. The next group 7 with `last` -> 7, proving the restart from EMPTY.
- Four products of 16383 -> `out_data=32767`, `out_sat=1`. Four products of −16384 -> `out_data=−32768`, `out_sat=1`.
- Backpressure:
  - Group 10 then 20 (`last` on 20) with `out_ready=0` -> `out_data=30` held and `in_ready=0` for 5 cycles.
  - Raise `out_ready` while `in_valid=1` presents product 4 with `last` -> 30 is consumed, 4 loads the next cycle, and `out_valid` stays high.
- Reset mid-group: products 1000, 2000, then `rst` for 1 cycle, then 7 with `last` -> `out_data=7`, `out_terms=1`; outputs are all zero during reset.
- `OUT_SHIFT=4`: group of −20, −13 (`last` on −13), sum −33 -> `out_data=−3`, `out_sat=0`. Group of 50 with `last` -> `out_data=3`.

Source files
------------

// File: rtl/mac_accumulator.sv
`timescale 1ns/1ps
// mac_accumulator: sums groups of signed products, then
// rescales and saturates each total onto a valid/ready register.
module mac_accumulator #(
  parameter int IN_WIDTH  = 15,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] out_terms
);

  typedef enum logic {
    EMPTY,
    RUN
  } state_t;

  localparam int PAD = ACC_WIDTH - IN_WIDTH;
  localparam int TOP = ACC_WIDTH - OUT_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    {{TOP{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV =
    ~MAXV;

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] shf;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH-1:0]        cnt_nxt;
  logic [OUT_WIDTH-1:0]        clip;
  logic                        take;
  logic                        hi;
  logic                        lo;

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  assign ext = {{PAD{in_data[IN_WIDTH-1]}}, in_data};

  // A fresh group ignores whatever acc/cnt still hold.
  always_comb begin
    base    = acc;
    cnt_nxt = cnt + 1'b1;
    if (state == EMPTY) begin
      base    = '0;
      cnt_nxt = CNT_WIDTH'(1);
    end
  end

  assign sum = base + ext;
  assign shf = sum >>> OUT_SHIFT;
  assign hi  = shf > MAXV;
  assign lo  = shf < MINV;

  always_comb begin
    clip = shf[OUT_WIDTH-1:0];
    unique case (1'b1)
      hi:      clip = MAXV[OUT_WIDTH-1:0];
      lo:      clip = MINV[OUT_WIDTH-1:0];
      default: clip = shf[OUT_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_terms <= '0;
    end else begin
      if (take) begin
        acc   <= sum;
        cnt   <= cnt_nxt;
        state <= in_last ? EMPTY : RUN;
      end
      if (take && in_last) begin
        out_valid <= 1'b1;
        out_data  <= clip;
        out_sat   <= hi || lo;
        out_terms <= cnt_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
`timescale 1ns/1ps
// tb_mac_accumulator: scoreboard bench, two instances
// (shift 0 and shift 4) driven by the same stream.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [14:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;
  logic [7:0]  out_terms;
  logic        in_ready4;
  logic        out_valid4;
  logic [15:0] out_data4;
  logic        out_sat4;
  logic [7:0]  out_terms4;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_terms (out_terms)
  );

  mac_accumulator #(.OUT_SHIFT(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .out_sat   (out_sat4),
    .out_terms (out_terms4)
  );

  typedef struct {
    int d0;
    int s0;
    int d4;
    int s4;
    int n;
  } exp_t;

  exp_t sb[$];
  int   grp[$];
  int   vec = 0;
  int   bad = 0;
  bit   hold_prev = 1'b0;
  int   hold_d = 0;

  task automatic chk(input string nm, input int act, input int req);
    vec++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(input int t[$]);
    longint s;
    int     a;
    exp_t   e;
    s = 0;
    foreach (t[i]) s += t[i];
    a    = int'(s);
    e.d0 = clamp(a);
    e.s0 = (a != e.d0) ? 1 : 0;
    e.d4 = clamp(a >>> 4);
    e.s4 = ((a >>> 4) != e.d4) ? 1 : 0;
    e.n  = t.size() % 256;
    return e;
  endfunction

  // Monitor: checks consumed results, then records accepted products.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      grp.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'($signed(out_data)), hold_d);
      end
      chk("valid_pair", int'(out_valid4), int'(out_valid));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vec++;
          bad++;
          $display("FAIL spurious: got result %0d, want none",
                   $signed(out_data));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data0", int'($signed(out_data)), e.d0);
          chk("sat0", int'(out_sat), e.s0);
          chk("terms", int'(out_terms), e.n);
          chk("data4", int'($signed(out_data4)), e.d4);
          chk("sat4", int'(out_sat4), e.s4);
          chk("terms4", int'(out_terms4), e.n);
        end
      end
      if (in_valid && in_ready) begin
        grp.push_back(int'($signed(in_data)));
        if (in_last) begin
          sb.push_back(model(grp));
          grp.delete();
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_d    = int'($signed(out_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit l);
    int n;
    in_valid = 1'b1;
    in_data  = 15'(d);
    in_last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        vec++;
        bad++;
        $display("FAIL send_timeout: got in_ready 0, want 1");
        break;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_terms", int'(out_terms), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);
    tick();

    // 100 - 30 + 5, single-cycle valid
    out_ready = 1'b1;
    send(100, 0);
    send(-30, 0);
    send(5, 1);
    in_valid = 1'b0;
    chk("pulse_hi", int'(out_valid), 1);
    tick();
    chk("pulse_lo", int'(out_valid), 0);

    // single product groups, back to back
    send(-16384, 1);
    send(7, 1);
    idle(2);

    // saturation both ways
    repeat (3) send(16383, 0);
    send(16383, 1);
    repeat (3) send(-16384, 0);
    send(-16384, 1);
    idle(2);

    // counter wrap: 300 terms
    repeat (299) send(1, 0);
    send(1, 1);
    idle(2);

    // backpressure
    out_ready = 1'b0;
    send(10, 0);
    send(20, 1);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_data", int'($signed(out_data)), 30);
    end
    tick();
    out_ready = 1'b1;
    send(4, 1);
    in_valid = 1'b0;
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_next", int'($signed(out_data)), 4);
    idle(2);

    // reset mid-group
    send(1000, 0);
    send(2000, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_data", int'(out_data), 0);
    chk("mid_terms", int'(out_terms), 0);
    rst = 1'b0;
    send(7, 1);
    in_valid = 1'b0;
    chk("mid_after", int'($signed(out_data)), 7);
    chk("mid_cnt", int'(out_terms), 1);
    idle(2);

    // shift-4 rounding toward -inf
    send(-20, 0);
    send(-13, 1);
    in_valid = 1'b0;
    chk("shift_neg", int'($signed(out_data4)), -3);
    send(50, 1);
    in_valid = 1'b0;
    chk("shift_pos", int'($signed(out_data4)), 3);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 9) < 2);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1)
        in_data = 15'($urandom);
      else
        in_data = 15'($signed(10'($urandom)));
      tick();
    end

    rst       = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
